// File: rtl/bsg_axil_to_req_responder.sv
// AXI4-Lite responder: buffers AW/W/AR independently and turns one transaction at a
// time into a valid/ready request, returning the client's response as B or R.
module bsg_axil_to_req_responder #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
) (
  input  logic                      aclk_i,
  input  logic                      aresetn_i,

  input  logic [addr_width_p-1:0]   awaddr_i,
  input  logic [2:0]                awprot_i,
  input  logic                      awvalid_i,
  output logic                      awready_o,

  input  logic [data_width_p-1:0]   wdata_i,
  input  logic [data_width_p/8-1:0] wstrb_i,
  input  logic                      wvalid_i,
  output logic                      wready_o,

  output logic [1:0]                bresp_o,
  output logic                      bvalid_o,
  input  logic                      bready_i,

  input  logic [addr_width_p-1:0]   araddr_i,
  input  logic [2:0]                arprot_i,
  input  logic                      arvalid_i,
  output logic                      arready_o,

  output logic [data_width_p-1:0]   rdata_o,
  output logic [1:0]                rresp_o,
  output logic                      rvalid_o,
  input  logic                      rready_i,

  output logic                      req_v_o,
  output logic                      req_w_o,
  output logic [addr_width_p-1:0]   req_addr_o,
  output logic [data_width_p-1:0]   req_data_o,
  output logic [data_width_p/8-1:0] req_mask_o,
  input  logic                      req_ready_i,

  input  logic                      resp_v_i,
  input  logic [data_width_p-1:0]   resp_data_i,
  input  logic                      resp_err_i,
  output logic                      resp_ready_o
);

  localparam int mask_width_lp = data_width_p / 8;

  typedef enum logic [2:0] {
    IDLE, REQ_WR, REQ_RD, WAIT_WR, WAIT_RD, B_RESP, R_RESP
  } state_e;

  state_e state_r, state_n;

  logic                     aw_full_r, w_full_r, ar_full_r;
  logic [addr_width_p-1:0]  aw_addr_r, ar_addr_r;
  logic [data_width_p-1:0]  w_data_r;
  logic [mask_width_lp-1:0] w_strb_r;
  logic                     rr_r;
  logic                     berr_r, rerr_r;
  logic [data_width_p-1:0]  rdata_r;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic wr_pend, rd_pend, pick_wr, pick_rd, issue_wr, issue_rd;

  logic unused_prot;
  assign unused_prot = ^{awprot_i, arprot_i};

  assign aw_hs = awvalid_i & ~aw_full_r;
  assign w_hs  = wvalid_i  & ~w_full_r;
  assign ar_hs = arvalid_i & ~ar_full_r;
  assign b_hs  = (state_r == B_RESP) & bready_i;
  assign r_hs  = (state_r == R_RESP) & rready_i;

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      state_r   <= IDLE;
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      ar_full_r <= 1'b0;
      aw_addr_r <= '0;
      ar_addr_r <= '0;
      w_data_r  <= '0;
      w_strb_r  <= '0;
      rr_r      <= 1'b0;
      berr_r    <= 1'b0;
      rerr_r    <= 1'b0;
      rdata_r   <= '0;
    end else begin
      state_r <= state_n;

      if (aw_hs) begin
        aw_full_r <= 1'b1;
        aw_addr_r <= awaddr_i;
      end else if (b_hs) begin
        aw_full_r <= 1'b0;
      end

      if (w_hs) begin
        w_full_r <= 1'b1;
        w_data_r <= wdata_i;
        w_strb_r <= wstrb_i;
      end else if (b_hs) begin
        w_full_r <= 1'b0;
      end

      if (ar_hs) begin
        ar_full_r <= 1'b1;
        ar_addr_r <= araddr_i;
      end else if (r_hs) begin
        ar_full_r <= 1'b0;
      end

      if (b_hs)      rr_r <= 1'b1;
      else if (r_hs) rr_r <= 1'b0;

      if ((state_r == WAIT_WR) && resp_v_i) berr_r <= resp_err_i;
      if ((state_r == WAIT_RD) && resp_v_i) begin
        rerr_r  <= resp_err_i;
        rdata_r <= resp_data_i;
      end
    end
  end

  // IDLE presents the arbitrated request directly from the registered flags, so the
  // request appears one cycle after the handshake; REQ_* only holds it under backpressure.
  always_comb begin
    wr_pend  = aw_full_r & w_full_r;
    rd_pend  = ar_full_r;
    pick_wr  = wr_pend & (~rd_pend | ~rr_r);
    pick_rd  = rd_pend & (~wr_pend | rr_r);
    issue_wr = (state_r == REQ_WR) | ((state_r == IDLE) & pick_wr);
    issue_rd = (state_r == REQ_RD) | ((state_r == IDLE) & pick_rd);

    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (pick_wr)      state_n = req_ready_i ? WAIT_WR : REQ_WR;
        else if (pick_rd) state_n = req_ready_i ? WAIT_RD : REQ_RD;
      end
      REQ_WR:  if (req_ready_i) state_n = WAIT_WR;
      REQ_RD:  if (req_ready_i) state_n = WAIT_RD;
      WAIT_WR: if (resp_v_i)    state_n = B_RESP;
      WAIT_RD: if (resp_v_i)    state_n = R_RESP;
      B_RESP:  if (bready_i)    state_n = IDLE;
      R_RESP:  if (rready_i)    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign awready_o    = ~aw_full_r;
  assign wready_o     = ~w_full_r;
  assign arready_o    = ~ar_full_r;

  assign req_v_o      = issue_wr | issue_rd;
  assign req_w_o      = issue_wr;
  assign req_addr_o   = issue_wr ? aw_addr_r : ar_addr_r;
  assign req_data_o   = issue_wr ? w_data_r  : '0;
  assign req_mask_o   = issue_wr ? w_strb_r  : '0;

  assign resp_ready_o = (state_r == WAIT_WR) | (state_r == WAIT_RD);

  assign bvalid_o     = (state_r == B_RESP);
  assign bresp_o      = {berr_r, 1'b0};
  assign rvalid_o     = (state_r == R_RESP);
  assign rresp_o      = {rerr_r, 1'b0};
  assign rdata_o      = rdata_r;

endmodule

// File: tb/tb_bsg_axil_to_req_responder.sv
// Bench for bsg_axil_to_req_responder: directed scenarios plus random traffic checked
// against a word-addressed memory model of what the AXI master has written.
module tb_bsg_axil_to_req_responder;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr, araddr, wdata, rdata_o, req_addr_o, req_data_o, resp_data;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb, req_mask_o;
  logic [1:0]  bresp_o, rresp_o;
  logic        awvalid, awready_o, wvalid, wready_o, bvalid_o, bready;
  logic        arvalid, arready_o, rvalid_o, rready;
  logic        req_v_o, req_w_o, req_ready, resp_v, resp_err, resp_ready_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem  [8];
  logic [31:0] client_mem [8];

  always #5 clk = ~clk;

  bsg_axil_to_req_responder #(.addr_width_p(32), .data_width_p(32)) dut (
    .aclk_i(clk), .aresetn_i(aresetn),
    .awaddr_i(awaddr), .awprot_i(awprot), .awvalid_i(awvalid), .awready_o(awready_o),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
    .araddr_i(araddr), .arprot_i(arprot), .arvalid_i(arvalid), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready),
    .req_v_o(req_v_o), .req_w_o(req_w_o), .req_addr_o(req_addr_o),
    .req_data_o(req_data_o), .req_mask_o(req_mask_o), .req_ready_i(req_ready),
    .resp_v_i(resp_v), .resp_data_i(resp_data), .resp_err_i(resp_err),
    .resp_ready_o(resp_ready_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_awready"}, awready_o, 1);
    chk({tag, "_wready"},  wready_o,  1);
    chk({tag, "_arready"}, arready_o, 1);
    chk({tag, "_bvalid"},  bvalid_o,  0);
    chk({tag, "_rvalid"},  rvalid_o,  0);
    chk({tag, "_req_v"},   req_v_o,   0);
    chk({tag, "_resp_rdy"}, resp_ready_o, 0);
  endtask

  // first channel at cycle 0, the other at cycle 'delay'
  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int delay, input bit w_first);
    awaddr = a; wdata = d; wstrb = s;
    if (delay == 0) begin
      awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
    end else begin
      if (w_first) wvalid = 1; else awvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      for (int i = 1; i <= delay; i++) begin
        chk("first_ready_low", w_first ? wready_o : awready_o, 0);
        chk("no_req_early", req_v_o, 0);
        if (i < delay) tick();
      end
      if (w_first) awvalid = 1; else wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
    end
  endtask

  task automatic send_ar(input logic [31:0] a);
    araddr = a; arvalid = 1;
    tick();
    arvalid = 0;
  endtask

  // plays the local client: accepts one request, then returns a response
  task automatic serve(input bit exp_w, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                       input logic [3:0] exp_mask, input int stall, input int rdelay,
                       input bit err, input bit stray);
    int n;
    logic [31:0] oa, od;
    logic [3:0]  om;
    n = 0;
    while (req_v_o !== 1'b1 && n < 40) begin tick(); n++; end
    chk("req_v", req_v_o, 1);
    chk("req_w", req_w_o, exp_w);
    chk("req_addr", req_addr_o, exp_addr);
    chk("req_data", req_data_o, exp_data);
    chk("req_mask", req_mask_o, exp_mask);
    chk("resp_ready_in_req", resp_ready_o, 0);
    oa = req_addr_o; od = req_data_o; om = req_mask_o;
    for (int i = 0; i < stall; i++) begin
      resp_v = stray; resp_err = 1; resp_data = $urandom;
      tick();
      chk("req_v_stall", req_v_o, 1);
      chk("req_addr_stall", req_addr_o, exp_addr);
      chk("req_data_stall", req_data_o, exp_data);
      chk("req_mask_stall", req_mask_o, exp_mask);
      chk("resp_ready_stray", resp_ready_o, 0);
      chk("no_b_stray", bvalid_o | rvalid_o, 0);
    end
    resp_v = 0; resp_err = 0;
    req_ready = 1;
    tick();
    req_ready = 0;
    for (int i = 0; i < rdelay; i++) begin
      chk("resp_ready_wait", resp_ready_o, 1);
      chk("no_resp_yet", bvalid_o | rvalid_o, 0);
      tick();
    end
    chk("resp_ready", resp_ready_o, 1);
    resp_v = 1; resp_err = err;
    resp_data = exp_w ? $urandom : client_mem[oa[4:2]];
    if (exp_w && !err) client_mem[oa[4:2]] = merge(client_mem[oa[4:2]], od, om);
    tick();
    resp_v = 0; resp_err = 0;
  endtask

  task automatic finish_b(input logic [1:0] exp_resp, input int delay);
    int n;
    n = 0;
    while (bvalid_o !== 1'b1 && n < 20) begin tick(); n++; end
    chk("bvalid", bvalid_o, 1);
    chk("bresp", bresp_o, exp_resp);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("bvalid_hold", bvalid_o, 1);
      chk("bresp_hold", bresp_o, exp_resp);
      chk("awready_busy", awready_o, 0);
    end
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_drop", bvalid_o, 0);
  endtask

  task automatic finish_r(input logic [31:0] exp_data, input logic [1:0] exp_resp,
                          input int delay);
    int n;
    n = 0;
    while (rvalid_o !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rvalid", rvalid_o, 1);
    chk("rdata", rdata_o, exp_data);
    chk("rresp", rresp_o, exp_resp);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("rvalid_hold", rvalid_o, 1);
      chk("rdata_hold", rdata_o, exp_data);
      chk("rresp_hold", rresp_o, exp_resp);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_drop", rvalid_o, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit err, input int delay, input bit w_first, input int stall,
                          input int rdelay, input int bdelay, input bit stray);
    send_aw_w(a, d, s, delay, w_first);
    serve(1, a, d, s, stall, rdelay, err, stray);
    finish_b(err ? 2'b10 : 2'b00, bdelay);
    if (!err) model_mem[a[4:2]] = merge(model_mem[a[4:2]], d, s);
  endtask

  task automatic do_read(input logic [31:0] a, input bit err, input int stall,
                         input int rdelay, input int rrdelay, input bit stray);
    send_ar(a);
    serve(0, a, 32'h0, 4'h0, stall, rdelay, err, stray);
    finish_r(model_mem[a[4:2]], err ? 2'b10 : 2'b00, rrdelay);
  endtask

  task automatic send_tie(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
    awaddr = wa; wdata = wd; wstrb = 4'hF; araddr = ra;
    awvalid = 1; wvalid = 1; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
  endtask

  task automatic do_reset();
    aresetn = 0;
    tick();
    tick();
    aresetn = 1;
  endtask

  initial begin
    logic [31:0] a, d;
    aresetn = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0; req_ready = 0;
    resp_v = 0; resp_data = 0; resp_err = 0;
    for (int i = 0; i < 8; i++) begin model_mem[i] = 0; client_mem[i] = 0; end

    // reset state
    tick();
    tick();
    check_idle_outputs("reset");
    chk("reset_bresp", bresp_o, 0);
    chk("reset_rresp", rresp_o, 0);
    chk("reset_rdata", rdata_o, 0);
    aresetn = 1;

    // single write, minimum latency
    awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; req_ready = 1; resp_v = 1; resp_err = 0; resp_data = 0;
    tick();
    awvalid = 0; wvalid = 0;
    chk("lat_req_v", req_v_o, 1);
    chk("lat_req_w", req_w_o, 1);
    chk("lat_req_addr", req_addr_o, 32'h10);
    chk("lat_req_data", req_data_o, 32'hDEADBEEF);
    chk("lat_req_mask", req_mask_o, 4'hF);
    tick();
    chk("lat_resp_ready", resp_ready_o, 1);
    chk("lat_no_b_yet", bvalid_o, 0);
    tick();
    req_ready = 0; resp_v = 0;
    chk("lat_bvalid", bvalid_o, 1);
    chk("lat_bresp", bresp_o, 0);
    bready = 1;
    tick();
    bready = 0;
    chk("lat_bvalid_drop", bvalid_o, 0);
    model_mem[4] = 32'hDEADBEEF; client_mem[4] = 32'hDEADBEEF;

    // W five cycles before AW
    do_write(32'h20, 32'hCAFEF00D, 4'hF, 0, 5, 1, 0, 0, 0, 0);

    // read with error and backpressure on every side
    do_write(32'h24, 32'h00001234, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    do_read(32'h24, 1, 4, 0, 3, 1);

    // stray response while idle
    resp_v = 1; resp_err = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_idle_ready", resp_ready_o, 0);
      chk("stray_idle_noresp", bvalid_o | rvalid_o, 0);
    end
    resp_v = 0; resp_err = 0;

    // tie arbitration: write, read (rr -> 0), tie again: write, read
    do_reset();
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      send_tie(32'h08, d, 32'h0C);
      serve(1, 32'h08, d, 4'hF, k, 0, 0, 0);
      finish_b(2'b00, 1);
      model_mem[2] = d;
      serve(0, 32'h0C, 32'h0, 4'h0, 0, 1, 0, 0);
      finish_r(model_mem[3], 2'b00, 0);
    end
    // after a B (rr -> 1), a tie goes to the read
    do_write(32'h0C, 32'h5A5A0000, 4'hC, 0, 0, 0, 0, 0, 0, 0);
    d = $urandom;
    send_tie(32'h1C, d, 32'h0C);
    serve(0, 32'h0C, 32'h0, 4'h0, 0, 0, 0, 0);
    finish_r(model_mem[3], 2'b00, 0);
    serve(1, 32'h1C, d, 4'hF, 0, 0, 0, 0);
    finish_b(2'b00, 0);
    model_mem[7] = d;

    // random traffic
    for (int t = 0; t < 40; t++) begin
      a = ($urandom & 32'hFFFF_FFE3) | ({29'h0, 3'($urandom_range(0, 7))} << 2);
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
      else
        do_read(a, ($urandom_range(0, 4) == 0), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
    end

    // reset while waiting on a read response
    send_ar(32'h04);
    begin
      int n;
      n = 0;
      while (req_v_o !== 1'b1 && n < 20) begin tick(); n++; end
      chk("rst_req_v", req_v_o, 1);
    end
    req_ready = 1;
    tick();
    req_ready = 0;
    chk("rst_in_wait", resp_ready_o, 1);
    aresetn = 0;
    tick();
    aresetn = 1;
    check_idle_outputs("midrst");
    chk("midrst_rdata", rdata_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_r", rvalid_o | req_v_o, 0);
    end
    do_write(32'h14, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    do_read(32'h14, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_axil_to_req_responder.md
Name: bsg_axil_to_req_responder

Overview:
- AXI4-Lite responder (slave) that terminates a single AXI-lite port and converts each transaction into a simple valid/ready request plus a returned response.
- Sits opposite an AXI-lite initiator, either the PS GP port or a DPI-driven initiator in cosim, and feeds a local register or memory client.
- Handles one transaction at a time.
- AW, W and AR are buffered independently; reads and writes are arbitrated round-robin.

Parameters:
- addr_width_p, 32, AXI-lite and request address width.
- data_width_p, 32, AXI-lite and request data width; must be a multiple of 8.

Ports:
- aclk_i  in  1  clock.
- aresetn_i  in  1  reset; synchronous, active-low.
- awaddr_i  in  addr_width_p  write address.
- awprot_i  in  3  ignored.
- awvalid_i  in  1.
- awready_o  out  1.
- wdata_i  in  data_width_p.
- wstrb_i  in  data_width_p/8.
- wvalid_i  in  1.
- wready_o  out  1.
- bresp_o  out  2.
- bvalid_o  out  1.
- bready_i  in  1.
- araddr_i  in  addr_width_p.
- arprot_i  in  3  ignored.
- arvalid_i  in  1.
- arready_o  out  1.
- rdata_o  out  data_width_p.
- rresp_o  out  2.
- rvalid_o  out  1.
- rready_i  in  1.
- req_v_o  out  1  request valid.
- req_w_o  out  1  1 = write, 0 = read.
- req_addr_o  out  addr_width_p.
- req_data_o  out  data_width_p  write data; 0 on reads.
- req_mask_o  out  data_width_p/8  write strobe; 0 on reads.
- req_ready_i  in  1.
- resp_v_i  in  1.
- resp_data_i  in  data_width_p  read data; ignored for writes.
- resp_err_i  in  1  1 = SLVERR.
- resp_ready_o  out  1.

Behaviour:
- Reset: synchronous, sampled at the aclk_i rising edge while aresetn_i = 0. It clears all holding registers, the FSM (to IDLE), the rr flag (to 0) and rdata/rresp/bresp registers.
  - Outputs during and after reset: awready_o = wready_o = arready_o = 1, all valid outputs 0, bresp_o = rresp_o = 0, rdata_o = 0.
  - Reset mid-transaction drops the transaction silently; no B/R is issued for it.
- Holding registers: aw_full, w_full and ar_full, one entry each.
  - awready_o = ~aw_full, wready_o = ~w_full, arready_o = ~ar_full.
  - Each is set on its own handshake; AW and W may arrive in any order or in the same cycle.
  - Each is cleared only on the B handshake (aw, w) or the R handshake (ar). No new AW/W is accepted until the prior B completes.
- Pending flags: wr_pend = aw_full & w_full; rd_pend = ar_full.
- FSM states:
  - IDLE → REQ_WR if wr_pend & (~rd_pend | ~rr).
  - IDLE → REQ_RD if rd_pend & (~wr_pend | rr).
  - The decision uses registered flags, so req_v_o rises no earlier than one cycle after the completing AW/W/AR handshake.
  - REQ_WR/REQ_RD: req_v_o = 1, fields driven from the holding registers. On req_v_o & req_ready_i → WAIT_WR/WAIT_RD. Fields stay stable while req_v_o = 1 and req_ready_i = 0.
  - WAIT_*: resp_ready_o = 1. On resp_v_i, capture resp_err_i (and resp_data_i for reads into rdata_o), then → B_RESP/R_RESP. resp_v_i in any other state is ignored (resp_ready_o = 0).
  - B_RESP: bvalid_o = 1, bresp_o = err ? 2'b10 : 2'b00. On bready_i: clear aw_full and w_full, set rr = 1, → IDLE.
  - R_RESP: rvalid_o = 1, rresp_o likewise; rdata_o is held. On rready_i: clear ar_full, set rr = 0, → IDLE.
- Arbitration: rr = 0 favours write and rr = 1 favours read, so a tie after a write goes to the read and vice versa. The first tie after reset goes to the write.
- Minimum latency: AW+W handshake at cycle 0 → req_v_o at 1 → resp accepted at 2 (if req_ready_i and resp_v_i are immediate) → bvalid_o at 3.
- Handshakes: bvalid_o and rvalid_o are not dependent on bready_i or rready_i. All outputs are registered or derived from state only; there is no combinational path from any input to any valid/ready output.
- New AR/AW/W may be accepted into empty holding registers in any FSM state.

Test Plan:
- Single write: AW addr 0x10 and W data 0xDEADBEEF, strb 0xF, same cycle; req_ready_i and resp_v_i tied 1 → req_v_o = 1, req_w_o = 1, addr 0x10, data 0xDEADBEEF, mask 0xF at cycle 1; bvalid_o = 1, bresp_o = 0 at cycle 3.
- W before AW: W at cycle 0, AW at cycle 5 → wready_o = 0 during cycles 1–5; no req_v_o before cycle 6; req fields correct.
- Read with error and backpressure: AR 0x24; req_ready_i low 4 cycles; resp_v_i with data 0x1234, err 1; rready_i low 3 cycles → req fields stable throughout the stall; rvalid_o held; rdata_o = 0x1234, rresp_o = 2'b10.
- Tie arbitration: AW+W and AR pending in the same cycle after reset → write issued first, then read. Repeat both pending again immediately after the read's R handshake (rr = 0) → write first. Pending both after a B (rr = 1) → read first.
- Stray response: resp_v_i = 1 while in IDLE and in REQ_* states → resp_ready_o = 0; no B/R generated.
- Reset mid-op: assert aresetn_i = 0 in WAIT_RD for 1 cycle → next cycle all valid outputs 0 and all ready outputs 1. A subsequent write completes normally with bresp_o = 0.
